// File: rtl/spi_share_arb_pkg.sv
// Shared types and helpers for the SPI bus-sharing arbiter.
// Holds the arbiter FSM encoding and the one-hot to index conversion.
package spi_share_arb_pkg;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbGrant,
    ArbGap
  } arb_state_e;

  // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic int onehot_to_idx(input logic [31:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_share_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from NumReq-1 back to 0. Output is one-hot or all-zero.
module rr_arbiter #(
  parameter int NumReq = 4,
  localparam int IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] winner
);

  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int off = 0; off < NumReq; off++) begin
      int cand;
      cand = (int'(ptr) + off) % NumReq;
      if (!found && req[cand]) begin
        winner[cand] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_share_arb.sv
// Shares one SPI bus between NumReq hosts: round-robin grant held for a whole
// transaction, enforced all-CS-high gap between owners, and a stuck-owner watchdog.
module spi_share_arb
  import spi_share_arb_pkg::*;
#(
  parameter int   NumReq        = 4,
  parameter int   CsGapCycles   = 2,
  parameter int   TimeoutCycles = 65535,
  parameter logic IdleSck       = 1'b0,
  localparam int  IdxW          = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] cs_req_i,
  input  logic [NumReq-1:0] sck_i,
  input  logic [NumReq-1:0] tx_i,
  output logic [NumReq-1:0] rx_o,
  output logic [NumReq-1:0] gnt_o,
  output logic              spi_sck_o,
  output logic              spi_tx_o,
  input  logic              spi_rx_i,
  output logic [NumReq-1:0] spi_cs_no,
  output logic              busy_o,
  output logic              timeout_o,
  output logic [IdxW-1:0]   timeout_id_o
);

  localparam int WdW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int GapW = $clog2(CsGapCycles + 1);

  arb_state_e        state;
  logic [NumReq-1:0] mask;
  logic [NumReq-1:0] eligible;
  logic [NumReq-1:0] winner;
  logic [IdxW-1:0]   ptr;
  logic [IdxW-1:0]   owner;
  logic [IdxW-1:0]   ptr_next;
  logic [WdW-1:0]    wd_cnt;
  logic [GapW-1:0]   gap_cnt;
  logic              wd_expire;
  logic              can_arb;

  assign eligible  = req_i & ~mask;
  assign owner     = IdxW'(onehot_to_idx(32'(gnt_o)));
  assign ptr_next  = IdxW'((onehot_to_idx(32'(winner)) + 1) % NumReq);
  assign wd_expire = (TimeoutCycles != 0) && (int'(wd_cnt) + 1 == TimeoutCycles);
  // The last gap cycle doubles as the arbitration cycle, so all CS stay high
  // for exactly CsGapCycles cycles between two owners.
  assign can_arb   = (state == ArbIdle) || ((state == ArbGap) && (gap_cnt == GapW'(1)));
  assign busy_o    = (state != ArbIdle);

  rr_arbiter #(.NumReq(NumReq)) u_rr (
    .req    (eligible),
    .ptr    (ptr),
    .winner (winner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ArbIdle;
      gnt_o        <= '0;
      ptr          <= '0;
      mask         <= '0;
      wd_cnt       <= '0;
      gap_cnt      <= '0;
      timeout_o    <= 1'b0;
      timeout_id_o <= '0;
    end else begin
      timeout_o <= 1'b0;
      mask      <= mask & req_i;
      case (state)
        ArbGrant: begin
          if (!req_i[owner]) begin
            state   <= ArbGap;
            gnt_o   <= '0;
            gap_cnt <= GapW'(CsGapCycles);
          end else if (wd_expire) begin
            state        <= ArbGap;
            gnt_o        <= '0;
            gap_cnt      <= GapW'(CsGapCycles);
            timeout_o    <= 1'b1;
            timeout_id_o <= owner;
            mask         <= (mask & req_i) | gnt_o;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          if (state == ArbGap) gap_cnt <= gap_cnt - 1'b1;
          if (can_arb) begin
            if (|eligible) begin
              state  <= ArbGrant;
              gnt_o  <= winner;
              ptr    <= ptr_next;
              wd_cnt <= '0;
            end else begin
              state <= ArbIdle;
            end
          end
        end
      endcase
    end
  end

  // Bus mux: only the registered owner reaches the shared pins.
  always_comb begin
    spi_sck_o = IdleSck;
    spi_tx_o  = 1'b0;
    spi_cs_no = '1;
    rx_o      = '0;
    if (state == ArbGrant) begin
      spi_sck_o        = sck_i[owner];
      spi_tx_o         = tx_i[owner];
      spi_cs_no[owner] = ~cs_req_i[owner];
      rx_o[owner]      = spi_rx_i;
    end
  end

endmodule
